// File: rtl/axi_pkg.sv
// axi_pkg: shared state encoding and AXI4 field constants for the burst master
// and its beat counter.
package axi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WADDR,
      WDATA,
      WRESP,
      RADDR,
      RDATA,
      DONE
   } state_t;

   localparam logic [1:0]  BURST_INCR  = 2'b01;
   localparam logic [2:0]  SIZE_4B     = 3'b010;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   // One past the last byte offset of a 4 KiB page, in the 14-bit span arithmetic.
   localparam logic [13:0] BOUNDARY_4K = 14'd4096;

endpackage

// File: rtl/axi_burst_beat_cnt.sv
// axi_burst_beat_cnt: beat counter with last-beat compare, shared by the W and R
// paths since only one transaction is ever in flight.
module axi_burst_beat_cnt (
   input  logic       clock,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   input  logic [7:0] len,
   output logic       last
);

   logic [7:0] cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= 8'd0;
      end else if (clr) begin
         cnt <= 8'd0;
      end else if (inc) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign last = (cnt == len);

endmodule

// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI4 INCR burst initiator for a local client.
// Optional: define AXI_BURST_MASTER_WCONCUR_EN to let W beats overlap the AW handshake.
module axi_burst_master
   import axi_pkg::*;
#(
   parameter logic [3:0] AXI_ID   = 4'h0,
   parameter bit         CHECK_4K = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [7:0]  req_len,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_strb,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [31:0] rd_data,
   output logic        rd_last,
   output logic        done_valid,
   output logic        done_err,
   output logic        out_awvalid,
   output logic [31:0] out_awaddr,
   output logic [3:0]  out_awid,
   output logic [7:0]  out_awlen,
   output logic [2:0]  out_awsize,
   output logic [1:0]  out_awburst,
   input  logic        out_awready,
   output logic        out_wvalid,
   output logic [31:0] out_wdata,
   output logic [3:0]  out_wstrb,
   output logic        out_wlast,
   input  logic        out_wready,
   input  logic        out_bvalid,
   input  logic [1:0]  out_bresp,
   input  logic [3:0]  out_bid,
   output logic        out_bready,
   output logic        out_arvalid,
   output logic [31:0] out_araddr,
   output logic [3:0]  out_arid,
   output logic [7:0]  out_arlen,
   output logic [2:0]  out_arsize,
   output logic [1:0]  out_arburst,
   input  logic        out_arready,
   input  logic        out_rvalid,
   input  logic [31:0] out_rdata,
   input  logic [1:0]  out_rresp,
   input  logic        out_rlast,
   input  logic [3:0]  out_rid,
   output logic        out_rready
);

   state_t      state;
   state_t      state_nx;
   logic [31:0] addr_q;
   logic [7:0]  len_q;
   logic        err_q;
   logic        err_nx;
   logic        accept;
   logic        bad_req;
   logic [13:0] span_end;
   logic        cnt_clr;
   logic        cnt_inc;
   logic        cnt_last;

   // Byte offset just past the burst within its page; > 4096 means a page crossing.
   assign span_end = {2'b00, req_addr[11:0]} + {4'b0000, req_len, 2'b00} + 14'd4;
   assign bad_req  = (req_addr[1:0] != 2'b00) || (CHECK_4K && (span_end > BOUNDARY_4K));
   assign accept   = (state == IDLE) && req_valid;

   assign out_awaddr  = addr_q;
   assign out_awlen   = len_q;
   assign out_awid    = AXI_ID;
   assign out_awsize  = SIZE_4B;
   assign out_awburst = BURST_INCR;
   assign out_araddr  = addr_q;
   assign out_arlen   = len_q;
   assign out_arid    = AXI_ID;
   assign out_arsize  = SIZE_4B;
   assign out_arburst = BURST_INCR;
   assign out_wdata   = wr_data;
   assign out_wstrb   = wr_strb;
   assign rd_data     = out_rdata;
   assign rd_last     = out_rlast;

   axi_burst_beat_cnt u_beat_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .len   (len_q),
      .last  (cnt_last)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         addr_q <= 32'd0;
         len_q  <= 8'd0;
         err_q  <= 1'b0;
      end else begin
         state <= state_nx;
         err_q <= err_nx;
         if (accept) begin
            addr_q <= req_addr;
            len_q  <= req_len;
         end
      end
   end

`ifdef AXI_BURST_MASTER_WCONCUR_EN
   logic aw_done_q;
   logic w_done_q;
   logic aw_done_nx;
   logic w_done_nx;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         aw_done_q <= aw_done_nx;
         w_done_q  <= w_done_nx;
      end
   end
`endif

   always_comb begin
      state_nx    = state;
      err_nx      = err_q;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      req_ready   = 1'b0;
      wr_ready    = 1'b0;
      rd_valid    = 1'b0;
      done_valid  = 1'b0;
      done_err    = 1'b0;
      out_awvalid = 1'b0;
      out_wvalid  = 1'b0;
      out_wlast   = 1'b0;
      out_bready  = 1'b0;
      out_arvalid = 1'b0;
      out_rready  = 1'b0;
`ifdef AXI_BURST_MASTER_WCONCUR_EN
      aw_done_nx  = aw_done_q;
      w_done_nx   = w_done_q;
`endif

      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               cnt_clr = 1'b1;
               err_nx  = 1'b0;
`ifdef AXI_BURST_MASTER_WCONCUR_EN
               aw_done_nx = 1'b0;
               w_done_nx  = 1'b0;
`endif
               if (bad_req) begin
                  err_nx   = 1'b1;
                  state_nx = DONE;
               end else begin
                  state_nx = req_we ? WADDR : RADDR;
               end
            end
         end

`ifdef AXI_BURST_MASTER_WCONCUR_EN
         // AW and W run side by side; each side latches its own completion.
         WADDR: begin
            out_awvalid = !aw_done_q;
            out_wvalid  = wr_valid && !w_done_q;
            wr_ready    = out_wready && !w_done_q;
            out_wlast   = cnt_last;
            if (out_awready) begin
               aw_done_nx = 1'b1;
            end
            if (wr_valid && out_wready && !w_done_q) begin
               cnt_inc = 1'b1;
               if (cnt_last) begin
                  w_done_nx = 1'b1;
               end
            end
            if (aw_done_nx && w_done_nx) begin
               state_nx = WRESP;
            end
         end
`else
         WADDR: begin
            out_awvalid = 1'b1;
            if (out_awready) begin
               state_nx = WDATA;
            end
         end
`endif

         WDATA: begin
            out_wvalid = wr_valid;
            wr_ready   = out_wready;
            out_wlast  = cnt_last;
            if (wr_valid && out_wready) begin
               cnt_inc = 1'b1;
               if (cnt_last) begin
                  state_nx = WRESP;
               end
            end
         end

         WRESP: begin
            out_bready = 1'b1;
            if (out_bvalid) begin
               if ((out_bresp != RESP_OKAY) || (out_bid != AXI_ID)) begin
                  err_nx = 1'b1;
               end
               state_nx = DONE;
            end
         end

         RADDR: begin
            out_arvalid = 1'b1;
            if (out_arready) begin
               state_nx = RDATA;
            end
         end

         // Beats past len keep flowing until the slave's rlast; a mismatch flags err.
         RDATA: begin
            out_rready = rd_ready;
            rd_valid   = out_rvalid;
            if (out_rvalid && rd_ready) begin
               cnt_inc = 1'b1;
               if ((out_rresp != RESP_OKAY) || (out_rid != AXI_ID) || (out_rlast != cnt_last)) begin
                  err_nx = 1'b1;
               end
               if (out_rlast) begin
                  state_nx = DONE;
               end
            end
         end

         DONE: begin
            done_valid = 1'b1;
            done_err   = err_q;
            state_nx   = IDLE;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule
